// File: rtl/eth_rx_frame.sv
// eth_rx_frame: 10BASE-T Manchester receiver. Synchronizes the raw RX line,
// recovers bits from mid-bit edges, locks on preamble/SFD, and writes the
// received bytes LSB-first into a BRAM port starting at address 0. On
// carrier loss the frame closes with length and error status.
// Optional build macro ETH_RX_CRC_EN adds a CRC-32 residue check over the
// stored bytes; without it rx_crc_ok is tied high.
//
// state | meaning
// IDLE  | line quiet, waiting for any edge
// HUNT  | bit timing acquired, shifting bits until the SFD pattern 0xD5
// DATA  | assembling payload bytes and writing them to BRAM
// CLOSE | one cycle: pulse rx_done, publish rx_len/rx_err/rx_crc_ok
module eth_rx_frame #(
  parameter int CLKS_PER_BIT = 10,
  parameter int ADDR_W       = 10,
  parameter int MAX_BYTES    = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              eth_rx,
  output logic              bram_wr_en,
  output logic [ADDR_W-1:0] bram_wr_addr,
  output logic [7:0]        bram_wr_data,
  output logic              rx_busy,
  output logic              rx_done,
  output logic [ADDR_W:0]   rx_len,
  output logic              rx_err,
  output logic              rx_crc_ok
);

  localparam int BLANK = (3 * CLKS_PER_BIT) / 4;
  localparam int TMO   = 2 * CLKS_PER_BIT;
  localparam int BW    = $clog2(BLANK + 1);
  localparam int TW    = $clog2(TMO);
  localparam logic [BW-1:0]   BLANK_LD = BW'(BLANK);
  localparam logic [TW-1:0]   TMO_LD   = TW'(TMO - 1);
  localparam logic [ADDR_W:0] MAX_CNT  = (ADDR_W + 1)'(MAX_BYTES);

  typedef enum logic [1:0] {IDLE, HUNT, DATA, CLOSE} state_t;

  state_t            state_q, state_d;
  logic              rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
  logic [BW-1:0]     blank_q, blank_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [ADDR_W:0]   byte_cnt_q, byte_cnt_d;
  logic              ovf_q, ovf_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              err_q, err_d;

  logic       edge_det, accept, timeout, bit_val;
  logic [7:0] shift_nxt;

`ifdef ETH_RX_CRC_EN
  logic [31:0] crc_q, crc_d;
  logic        crc_ok_q, crc_ok_d;

  // Reflected CRC-32 (poly 0x04C11DB7 -> 0xEDB88320), one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ b[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  assign rx_crc_ok = crc_ok_q;
`else
  assign rx_crc_ok = 1'b1;
`endif

  // The first edge out of IDLE defines bit timing, so it bypasses blanking.
  assign edge_det  = rx_sync_q ^ rx_prev_q;
  assign accept    = edge_det && ((state_q == IDLE) || (blank_q == '0));
  assign timeout   = !edge_det && (tmo_q == '0);
  assign bit_val   = rx_sync_q;
  assign shift_nxt = {bit_val, shift_q[7:1]};

  assign bram_wr_en   = wr_en_q;
  assign bram_wr_addr = wr_addr_q;
  assign bram_wr_data = wr_data_q;
  assign rx_busy      = (state_q == DATA) || (state_q == CLOSE);
  assign rx_done      = (state_q == CLOSE);
  assign rx_len       = len_q;
  assign rx_err       = err_q;

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_comb begin
    rx_meta_d = eth_rx;
    rx_sync_d = rx_meta_q;
    rx_prev_d = rx_sync_q;
  end

  // Next-state, bit recovery, byte assembly and write-port logic.
  always_comb begin
    state_d    = state_q;
    blank_d    = (blank_q != '0) ? blank_q - BW'(1) : '0;
    tmo_d      = (tmo_q != '0) ? tmo_q - TW'(1) : '0;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    ovf_d      = ovf_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    len_d      = len_q;
    err_d      = err_q;
`ifdef ETH_RX_CRC_EN
    crc_d      = crc_q;
    crc_ok_d   = crc_ok_q;
`endif

    // Any edge, mid-bit or boundary, proves the carrier is still present.
    if (edge_det) tmo_d = TMO_LD;
    if (accept) blank_d = BLANK_LD;

    case (state_q)
      IDLE: begin
        if (edge_det) begin
          state_d = HUNT;
          shift_d = {bit_val, 7'd0};
        end
      end
      HUNT: begin
        if (accept) begin
          shift_d = shift_nxt;
          if (shift_nxt == 8'hD5) begin
            state_d    = DATA;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = '0;
            ovf_d      = 1'b0;
`ifdef ETH_RX_CRC_EN
            crc_d      = 32'hFFFFFFFF;
`endif
          end
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (accept) begin
          shift_d   = shift_nxt;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (byte_cnt_q < MAX_CNT) begin
              wr_en_d    = 1'b1;
              wr_addr_d  = byte_cnt_q[ADDR_W-1:0];
              wr_data_d  = shift_nxt;
              byte_cnt_d = byte_cnt_q + (ADDR_W + 1)'(1);
`ifdef ETH_RX_CRC_EN
              crc_d      = crc32_byte(crc_q, shift_nxt);
`endif
            end else begin
              ovf_d = 1'b1;
            end
          end
        end else if (timeout) begin
          // Status is latched here so it is already valid while rx_done is high.
          state_d = CLOSE;
          len_d   = byte_cnt_q;
          err_d   = ovf_q | (bit_cnt_q != 3'd0);
`ifdef ETH_RX_CRC_EN
          crc_ok_d = !ovf_q && (crc_q == 32'hDEBB20E3);
`endif
        end
      end
      CLOSE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rx_meta_q  <= 1'b0;
      rx_sync_q  <= 1'b0;
      rx_prev_q  <= 1'b0;
      blank_q    <= '0;
      tmo_q      <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      ovf_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
`ifdef ETH_RX_CRC_EN
      crc_q      <= 32'hFFFFFFFF;
      crc_ok_q   <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      rx_prev_q  <= rx_prev_d;
      blank_q    <= blank_d;
      tmo_q      <= tmo_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      ovf_q      <= ovf_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      len_q      <= len_d;
      err_q      <= err_d;
`ifdef ETH_RX_CRC_EN
      crc_q      <= crc_d;
      crc_ok_q   <= crc_ok_d;
`endif
    end
  end

endmodule

// File: tb/tb_eth_rx_frame.sv
// Bench for eth_rx_frame: Manchester line driver with optional jitter, a
// monitor that records BRAM writes and close status, and a frame-level model
// (payload list -> expected writes, length, error, FCS status).
module tb_eth_rx_frame;

  localparam int CPB  = 10;
  localparam int AW   = 7;
  localparam int MAXB = 128;
  localparam int HALF = CPB / 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          eth_rx;
  logic          bram_wr_en;
  logic [AW-1:0] bram_wr_addr;
  logic [7:0]    bram_wr_data;
  logic          rx_busy;
  logic          rx_done;
  logic [AW:0]   rx_len;
  logic          rx_err;
  logic          rx_crc_ok;

  eth_rx_frame #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .MAX_BYTES(MAXB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .eth_rx       (eth_rx),
    .bram_wr_en   (bram_wr_en),
    .bram_wr_addr (bram_wr_addr),
    .bram_wr_data (bram_wr_data),
    .rx_busy      (rx_busy),
    .rx_done      (rx_done),
    .rx_len       (rx_len),
    .rx_err       (rx_err),
    .rx_crc_ok    (rx_crc_ok)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] pay_q[$];
  bit         bits_q[$];
  int         mon_addr[$];
  int         mon_data[$];
  int         done_cnt;
  int         cap_len;
  logic       cap_err, cap_crc;
  bit         busy_seen;
  bit         abort_tx;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Record writes and close status away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bram_wr_en) begin
        mon_addr.push_back(int'(bram_wr_addr));
        mon_data.push_back(int'(bram_wr_data));
      end
      if (rx_done) begin
        done_cnt++;
        cap_len = int'(rx_len);
        cap_err = rx_err;
        cap_crc = rx_crc_ok;
      end
      if (rx_busy) busy_seen = 1'b1;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Standard Ethernet CRC-32 (reflected, init all-ones, final inversion).
  function automatic logic [31:0] crc32_of(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) begin
        if (c[0] ^ pay_q[i][k]) c = (c >> 1) ^ 32'hEDB88320;
        else c = c >> 1;
      end
    end
    return ~c;
  endfunction

  task automatic append_fcs();
    logic [31:0] c;
    c = crc32_of(pay_q.size());
    pay_q.push_back(c[7:0]);
    pay_q.push_back(c[15:8]);
    pay_q.push_back(c[23:16]);
    pay_q.push_back(c[31:24]);
  endtask

  task automatic rand_payload(input int n);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int k = 0; k < 8; k++) bits_q.push_back(b[k]);
  endtask

  task automatic build_bits(input bit with_sfd, input int extra);
    bits_q.delete();
    for (int i = 0; i < 7; i++) push_byte(8'h55);
    if (with_sfd) begin
      push_byte(8'hD5);
      foreach (pay_q[i]) push_byte(pay_q[i]);
      for (int i = 0; i < extra; i++) bits_q.push_back(1'($urandom));
    end else begin
      push_byte(8'h55);
    end
  endtask

  // Each bit: first half = ~bit, second half = bit (rising mid-bit edge = 1).
  // Every half-bit boundary is moved by an independent -1/0/+1 clk offset.
  task automatic drive_line(input bit jit);
    int jp, jn, dur, last;
    jp = 0;
    last = bits_q.size() - 1;
    for (int i = 0; i <= last; i++) begin
      for (int h = 0; h < 2; h++) begin
        if (abort_tx) return;
        eth_rx = (h == 0) ? ~bits_q[i] : bits_q[i];
        if (jit && !(i == last && h == 1)) jn = int'($urandom_range(0, 2)) - 1;
        else jn = 0;
        dur = HALF + jn - jp;
        jp  = jn;
        wait_cyc(dur);
      end
    end
  endtask

  task automatic clear_mon();
    mon_addr.delete();
    mon_data.delete();
    done_cnt  = 0;
    busy_seen = 1'b0;
  endtask

  // Drive one frame, let carrier loss close it, then return the line low quietly.
  task automatic run_frame(input bit with_sfd, input int extra, input bit jit);
    clear_mon();
    build_bits(with_sfd, extra);
    abort_tx = 1'b0;
    drive_line(jit);
    wait_cyc(5 * CPB);
    if (eth_rx) begin
      eth_rx = 1'b0;
      wait_cyc(5 * CPB);
    end
  endtask

  task automatic check_frame(input string tag, input int extra);
    int   n, ns, lim;
    logic exp_ok;
    n  = pay_q.size();
    ns = (n > MAXB) ? MAXB : n;
    check_eq({tag, "_nwr"}, 32'(mon_addr.size()), 32'(ns));
    lim = (mon_addr.size() < ns) ? mon_addr.size() : ns;
    for (int i = 0; i < lim; i++) begin
      check_eq($sformatf("%s_addr%0d", tag, i), 32'(mon_addr[i]), 32'(i));
      check_eq($sformatf("%s_data%0d", tag, i), 32'(mon_data[i]), 32'(pay_q[i]));
    end
    check_eq({tag, "_done"}, 32'(done_cnt), 32'd1);
    check_eq({tag, "_len"}, 32'(cap_len), 32'(ns));
    check_eq({tag, "_err"}, 32'(cap_err), 32'((n > MAXB) || (extra != 0)));
`ifdef ETH_RX_CRC_EN
    if (n > MAXB || n < 4) exp_ok = 1'b0;
    else exp_ok = ({pay_q[n-1], pay_q[n-2], pay_q[n-3], pay_q[n-4]} == crc32_of(n - 4));
`else
    exp_ok = 1'b1;
`endif
    check_eq({tag, "_crc"}, 32'(cap_crc), 32'(exp_ok));
    check_eq({tag, "_busy"}, 32'(busy_seen), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    int idx;
    rst_n    = 1'b0;
    eth_rx   = 1'b0;
    abort_tx = 1'b0;
    clear_mon();
    wait_cyc(5);
    check_eq("rst_wr_en", 32'(bram_wr_en), 32'd0);
    check_eq("rst_wr_addr", 32'(bram_wr_addr), 32'd0);
    check_eq("rst_wr_data", 32'(bram_wr_data), 32'd0);
    check_eq("rst_busy", 32'(rx_busy), 32'd0);
    check_eq("rst_done", 32'(rx_done), 32'd0);
    check_eq("rst_len", 32'(rx_len), 32'd0);
    check_eq("rst_err", 32'(rx_err), 32'd0);
    check_eq("rst_crc_ok", 32'(rx_crc_ok), 32'd1);
    rst_n = 1'b1;
    wait_cyc(10);

    // Basic three-byte frame, clean timing.
    pay_q.delete();
    pay_q.push_back(8'h01);
    pay_q.push_back(8'h02);
    pay_q.push_back(8'hA5);
    run_frame(1'b1, 0, 1'b0);
    check_frame("basic", 0);

    // Preamble without SFD: nothing may happen.
    pay_q.delete();
    run_frame(1'b0, 0, 1'b0);
    check_eq("pre_nwr", 32'(mon_addr.size()), 32'd0);
    check_eq("pre_done", 32'(done_cnt), 32'd0);
    check_eq("pre_busy", 32'(busy_seen), 32'd0);

    // Random short frames, jittered, half with a valid FCS.
    for (int f = 0; f < 4; f++) begin
      rand_payload(int'($urandom_range(1, 20)));
      if (f[0]) append_fcs();
      run_frame(1'b1, 0, 1'b1);
      check_frame($sformatf("rnd%0d", f), 0);
    end

    // Overflow: more bytes than storage.
    rand_payload(MAXB + 6);
    run_frame(1'b1, 0, 1'b0);
    check_frame("ovf", 0);

    // Ends mid-byte: two bytes plus three stray bits.
    pay_q.delete();
    pay_q.push_back(8'h3C);
    pay_q.push_back(8'hE7);
    run_frame(1'b1, 3, 1'b0);
    check_frame("partial", 3);

    // 64-byte jittered frame with valid FCS, then the same with one bit flipped.
    rand_payload(60);
    append_fcs();
    run_frame(1'b1, 0, 1'b1);
    check_frame("jit64", 0);
    idx = int'($urandom_range(0, 59));
    pay_q[idx] = pay_q[idx] ^ (8'd1 << $urandom_range(0, 7));
    run_frame(1'b1, 0, 1'b1);
    check_frame("jit64_bad", 0);

    // Reset asserted while the fifth byte is being written.
    rand_payload(10);
    clear_mon();
    build_bits(1'b1, 0);
    abort_tx = 1'b0;
    hit = 1'b0;
    fork
      drive_line(1'b0);
      begin
        for (int k = 0; k < 3000 && !hit; k++) begin
          @(negedge clk);
          if (bram_wr_en && bram_wr_addr == AW'(4)) hit = 1'b1;
        end
        rst_n = 1'b0;
        #1;
        check_eq("abort_seen_wr4", 32'(hit), 32'd1);
        check_eq("abort_wr_en", 32'(bram_wr_en), 32'd0);
        check_eq("abort_busy", 32'(rx_busy), 32'd0);
        abort_tx = 1'b1;
      end
    join
    eth_rx = 1'b0;
    clear_mon();
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(6 * CPB);
    check_eq("abort_done", 32'(done_cnt), 32'd0);
    check_eq("abort_nwr", 32'(mon_addr.size()), 32'd0);
    check_eq("abort_len", 32'(rx_len), 32'd0);
    pay_q.delete();
    pay_q.push_back(8'h9A);
    pay_q.push_back(8'h00);
    pay_q.push_back(8'hFF);
    run_frame(1'b1, 0, 1'b0);
    check_frame("after_rst", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
